// File: rtl/act_arbiter.sv
// act_arbiter: round-robin arbiter sharing one (|x+c| + |x-c|) >>> sh activation unit.
// Define ACT_ARB_PIPE_EN to add the CALC state and a registered result (2-cycle latency).
`ifndef WIDTH
`define WIDTH 8
`endif

module act_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ID_W   = 2,
  parameter int ACT_C  = 4,
  parameter int ACT_SH = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*2*`WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [`WIDTH-1:0]  out_data,
  output logic [ID_W-1:0]           out_id,
  output logic                      busy
);

  localparam int W  = `WIDTH;
  localparam int DW = 2 * W;
  localparam logic signed [DW-1:0] CW = DW'(ACT_C);

`ifdef ACT_ARB_PIPE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, OUT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, OUT = 2'd2} state_t;
`endif

  state_t               state;
  logic [ID_W-1:0]      last_grant;
  logic signed [DW-1:0] operand;
  logic signed [DW-1:0] req_slice [N_REQ];
  logic                 gnt_found;
  logic [ID_W-1:0]      gnt_idx;

  // Full-width arithmetic; the caller truncates to W bits without saturation.
  function automatic logic signed [DW-1:0] act_f(input logic signed [DW-1:0] x);
    logic signed [DW-1:0] hi;
    logic signed [DW-1:0] lo;
    logic signed [DW-1:0] sum;
    hi = x + CW;
    lo = x - CW;
    if (hi[DW-1]) hi = -hi;
    if (lo[DW-1]) lo = -lo;
    sum = hi + lo;
    return sum >>> ACT_SH;
  endfunction

  always_comb begin
    for (int i = 0; i < N_REQ; i++) req_slice[i] = req_data[i*DW +: DW];
  end

  // Search upward from the requester after the last winner, wrapping at N_REQ.
  always_comb begin
    logic [ID_W-1:0] idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ID_W'((int'(last_grant) + k) % N_REQ);
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

`ifdef ACT_ARB_PIPE_EN
  logic signed [W-1:0] result;
  assign out_data = out_valid ? result : '0;
`else
  assign out_data = out_valid ? W'(act_f(operand)) : '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= ID_W'(N_REQ - 1);
      operand    <= '0;
      out_id     <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
`ifdef ACT_ARB_PIPE_EN
      result     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            operand    <= req_slice[gnt_idx];
            out_id     <= gnt_idx;
            last_grant <= gnt_idx;
            busy       <= 1'b1;
`ifdef ACT_ARB_PIPE_EN
            state      <= CALC;
`else
            state      <= OUT;
            out_valid  <= 1'b1;
`endif
          end
        end
`ifdef ACT_ARB_PIPE_EN
        CALC: begin
          result    <= W'(act_f(operand));
          state     <= OUT;
          out_valid <= 1'b1;
        end
`endif
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_act_arbiter.sv
// tb_act_arbiter: directed self-checking bench for act_arbiter with hand-computed vectors.
// Expected values assume WIDTH = 8 (operands are 16-bit slices).
`ifndef WIDTH
`define WIDTH 8
`endif

module tb_act_arbiter;

`ifdef ACT_ARB_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                     clk;
  logic                     reset;
  logic [3:0]               req_valid;
  logic [4*2*`WIDTH-1:0]    req_data;
  logic [3:0]               req_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [`WIDTH-1:0] out_data;
  logic [1:0]               out_id;
  logic                     busy;

  int vectors;
  int miscompares;
  int cyc;
  int got;
  int exp_ids [5] = '{0, 1, 2, 3, 0};
  int exp_dat [5] = '{10, 20, 6, 8, 10};

  act_arbiter #(.N_REQ(4), .ID_W(2), .ACT_C(4), .ACT_SH(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] v);
    req_valid = v;
    #1;
  endtask

  task automatic setData(input int id, input logic signed [15:0] x);
    req_data[id*16 +: 16] = x;
  endtask

  task automatic waitOut(output int c);
    c = 1;
    while (!out_valid && c < 10) begin
      tick();
      c++;
    end
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_done_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic runOne(input string tag, input logic [3:0] v, input int id,
                        input logic signed [15:0] x, input logic [7:0] exp_data);
    int c;
    setData(id, x);
    applyStimulus(v);
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << id));
    tick();
    req_valid = 4'b0000;
    waitOut(c);
    checkOutput({tag, "_latency"}, 32'(c), 32'(LAT));
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    checkOutput({tag, "_data"}, 32'($unsigned(out_data)), 32'(exp_data));
    checkOutput({tag, "_id"}, 32'(out_id), 32'(id));
    consume(tag);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    req_valid   = '0;
    req_data    = '0;
    out_ready   = 1'b0;
    #1 reset = 1'b1;
    #11;
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_data", 32'($unsigned(out_data)), 32'd0);
    checkOutput("rst_id", 32'(out_id), 32'd0);
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;

    // single requests, including truncation of large results
    runOne("x10", 4'b0001, 0, 16'sd10, 8'd10);
    runOne("x1", 4'b0001, 0, 16'sd1, 8'd4);
    runOne("xm7", 4'b0100, 2, -16'sd7, 8'd7);
    runOne("xm4", 4'b1000, 3, -16'sd4, 8'd4);
    runOne("x300", 4'b0010, 1, 16'sd300, 8'h2C);
    runOne("xm1000", 4'b0001, 0, -16'sd1000, 8'hE8);

    // round robin with all requesters valid, starting fresh from reset
    reset = 1'b1;
    #1 reset = 1'b0;
    setData(0, 16'sd10);
    setData(1, -16'sd20);
    setData(2, 16'sd6);
    setData(3, -16'sd8);
    out_ready = 1'b1;
    applyStimulus(4'b1111);
    checkOutput("rr_first_ready", 32'(req_ready), 32'd1);
    got = 0;
    cyc = 0;
    while (got < 5 && cyc < 60) begin
      tick();
      cyc++;
      if (out_valid) begin
        checkOutput($sformatf("rr_id%0d", got), 32'(out_id), 32'(exp_ids[got]));
        checkOutput($sformatf("rr_data%0d", got), 32'($unsigned(out_data)), 32'(exp_dat[got]));
        got++;
        if (got == 5) req_valid = 4'b0000;
      end
    end
    checkOutput("rr_count", 32'(got), 32'd5);
    tick();
    out_ready = 1'b0;
    checkOutput("rr_idle_busy", 32'(busy), 32'd0);

    // stall in OUT while every requester clamours
    setData(2, -16'sd7);
    applyStimulus(4'b0100);
    checkOutput("stall_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b1111;
    waitOut(cyc);
    checkOutput("stall_latency", 32'(cyc), 32'(LAT));
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("stall_valid%0d", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("stall_data%0d", i), 32'($unsigned(out_data)), 32'd7);
      checkOutput($sformatf("stall_id%0d", i), 32'(out_id), 32'd2);
      checkOutput($sformatf("stall_ready%0d", i), 32'(req_ready), 32'd0);
      checkOutput($sformatf("stall_busy%0d", i), 32'(busy), 32'd1);
      tick();
    end
    req_valid = 4'b0000;
    consume("stall");

    // asynchronous reset while a result is waiting
    setData(1, 16'sd100);
    applyStimulus(4'b0010);
    checkOutput("mid_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b0000;
    waitOut(cyc);
    checkOutput("mid_valid_before", 32'(out_valid), 32'd1);
    checkOutput("mid_data_before", 32'($unsigned(out_data)), 32'd100);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_data", 32'($unsigned(out_data)), 32'd0);
    checkOutput("mid_rst_id", 32'(out_id), 32'd0);
    reset = 1'b0;
    applyStimulus(4'b1111);
    checkOutput("post_rst_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0000;
    waitOut(cyc);
    checkOutput("post_rst_latency", 32'(cyc), 32'(LAT));
    checkOutput("post_rst_id", 32'(out_id), 32'd0);
    checkOutput("post_rst_data", 32'($unsigned(out_data)), 32'd10);
    consume("post_rst");

    // requester withdraws before the handshake edge
    runOne("g3", 4'b1000, 3, -16'sd8, 8'd8);
    applyStimulus(4'b0100);
    checkOutput("drop_ready_pre", 32'(req_ready), 32'b0100);
    applyStimulus(4'b0000);
    checkOutput("drop_ready_post", 32'(req_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("drop_valid%0d", i), 32'(out_valid), 32'd0);
      checkOutput($sformatf("drop_busy%0d", i), 32'(busy), 32'd0);
    end
    applyStimulus(4'b1111);
    checkOutput("drop_next_ready", 32'(req_ready), 32'b0001);
    req_valid = 4'b0000;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
